// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: data width, default oversampling,
// FSM state encoding and the parity-check helper.
package uart_rx_pkg;

  localparam int unsigned DATA_WIDTH          = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE  = 16;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  // High when the received parity bit disagrees with the selected parity.
  function automatic logic parity_mismatch(data_t data, logic par_bit, logic odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte stream: valid/ready handshake with per-byte error flags and
// the overrun pulse.
interface uart_rx_if;

  logic                 valid;
  logic                 ready;
  uart_rx_pkg::data_t   data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output valid,
    output data,
    output parity_err,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input; all stages reset
// to RESET_VAL so an idle-high line does not look like an edge after reset.
module uart_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1/8E1/8O1 frames sampled on the oversample tick, delivered on
// a valid/ready stream with parity/frame error flags and an overrun pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               oversample_tick,
  input  logic               rx,
  input  logic               parity_en,
  input  logic               parity_odd,
  uart_rx_if.master          out_if,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] MidTick  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_WIDTH - 1);

  logic rx_s;

  uart_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] tick_q, tick_d;
  logic [BitW-1:0] bit_q, bit_d;
  data_t           shift_q, shift_d;
  logic            par_en_q, par_en_d;
  logic            par_odd_q, par_odd_d;
  logic            perr_q, perr_d;
  logic            valid_q, valid_d;
  data_t           data_q, data_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      perr_q       <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      perr_q       <= perr_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    perr_d       = perr_q;
    valid_d      = valid_q;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    if (valid_q && out_if.ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (oversample_tick && !rx_s) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end
      StStart: begin
        if (oversample_tick) begin
          if (tick_q == MidTick) begin
            if (rx_s) begin
              state_d = StIdle;
            end else begin
              state_d   = StData;
              tick_d    = '0;
              bit_d     = '0;
              par_en_d  = parity_en;
              par_odd_d = parity_odd;
              perr_d    = 1'b0;
            end
          end else begin
            tick_d = tick_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (oversample_tick) begin
          if (tick_q == LastTick) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
            if (bit_q == LastBit) begin
              state_d = par_en_q ? StParity : StStop;
            end else begin
              bit_d = bit_q + BitW'(1);
            end
          end else begin
            tick_d = tick_q + CntW'(1);
          end
        end
      end
      StParity: begin
        if (oversample_tick) begin
          if (tick_q == LastTick) begin
            tick_d  = '0;
            perr_d  = parity_mismatch(shift_q, rx_s, par_odd_q);
            state_d = StStop;
          end else begin
            tick_d = tick_q + CntW'(1);
          end
        end
      end
      StStop: begin
        if (oversample_tick) begin
          if (tick_q == LastTick) begin
            tick_d = '0;
            // A pending byte is only replaced when it is accepted this very cycle.
            if (!valid_q || out_if.ready) begin
              valid_d      = 1'b1;
              data_d       = shift_q;
              parity_err_d = perr_q;
              frame_err_d  = ~rx_s;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = rx_s ? StIdle : StBreak;
          end else begin
            tick_d = tick_q + CntW'(1);
          end
        end
      end
      StBreak: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_if.valid      = valid_q;
  assign out_if.data       = data_q;
  assign out_if.parity_err = parity_err_q;
  assign out_if.frame_err  = frame_err_q;
  assign out_if.overrun    = overrun_q;
  assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit, expected
// bytes go into a scoreboard queue and are compared as the DUT hands them over.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BIT_CLKS = OS * TICK_DIV;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic oversample_tick = 1'b0;
  logic rx = 1'b1;
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  logic busy;

  uart_rx_if out_if ();

  uart_rx #(
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .oversample_tick (oversample_tick),
    .rx              (rx),
    .parity_en       (parity_en),
    .parity_odd      (parity_odd),
    .out_if          (out_if),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   delivered = 0;
  int   overruns  = 0;
  int   tick_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin : tick_gen
    forever begin
      @(negedge clk);
      oversample_tick = (tick_cnt == TICK_DIV - 1);
      tick_cnt = (tick_cnt + 1) % TICK_DIV;
    end
  end

  // Scoreboard: a handshake seen before the next rising edge pops one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (out_if.overrun) overruns++;
      if (out_if.valid && out_if.ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          check_eq("sb_beat_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_data", out_if.data, e.data);
          check_eq("sb_parity_err", out_if.parity_err, e.perr);
          check_eq("sb_frame_err", out_if.frame_err, e.ferr);
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic flip_par, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit((^d) ^ podd ^ flip_par);
    drive_bit(stop_v);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin : main
    int  d0;
    int  ov0;
    int  n;
    logic seen_busy;
    logic [7:0] a5;

    out_if.ready = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_valid", out_if.valid, 0);
    check_eq("rst_data", out_if.data, 0);
    check_eq("rst_parity_err", out_if.parity_err, 0);
    check_eq("rst_frame_err", out_if.frame_err, 0);
    check_eq("rst_overrun", out_if.overrun, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    out_if.ready = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // Single 8E1 frame
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push_exp(8'h41, 1'b0, 1'b0);
    send_frame(8'h41, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    wait_drain("t1_drain");
    check_eq("t1_overrun", overruns, 0);
    check_eq("t1_count", delivered, 1);

    // Back-to-back 8N1 frames, one stop bit each
    parity_en = 1'b0;
    push_exp(8'h00, 1'b0, 1'b0);
    push_exp(8'hFF, 1'b0, 1'b0);
    push_exp(8'h55, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    wait_drain("t2_drain");
    check_eq("t2_count", delivered, 4);

    // Corrupted parity bit under even parity
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push_exp(8'h41, 1'b1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b0, 1'b1, 1'b1);
    drive_bit(1'b1);
    wait_drain("t3_perr_drain");

    // Stop bit low followed by a held-low line: one byte, then BREAK
    push_exp(8'h41, 1'b0, 1'b1);
    send_frame(8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    check_eq("t3_break_busy", busy, 1);
    drive_bit(1'b1);
    check_eq("t3_break_exit", busy, 0);
    wait_drain("t3_ferr_drain");
    repeat (10) drive_bit(1'b1);
    check_eq("t3_count", delivered, 6);

    // Overrun: consumer stalled across two frames
    out_if.ready = 1'b0;
    parity_en = 1'b0;
    ov0 = overruns;
    push_exp(8'h12, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    check_eq("t4_valid_held", out_if.valid, 1);
    check_eq("t4_data_held", out_if.data, 8'h12);
    check_eq("t4_overrun_once", overruns, ov0 + 1);
    out_if.ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("t4_valid_cleared", out_if.valid, 0);
    check_eq("t4_count", delivered, 7);
    check_eq("t4_sb_empty", exp_q.size(), 0);

    // Short low glitch on the line
    d0 = delivered;
    seen_busy = 1'b0;
    rx = 1'b0;
    repeat (3 * TICK_DIV) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    rx = 1'b1;
    n = 0;
    while (n < OS * TICK_DIV && (busy || !seen_busy)) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      n++;
    end
    check_eq("t5_busy_seen", seen_busy, 1);
    check_eq("t5_busy_idle", busy, 0);
    repeat (12) drive_bit(1'b1);
    check_eq("t5_no_output", delivered, d0);

    // Reset in the middle of a frame, then a clean frame
    a5 = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(a5[i]);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_rst_valid", out_if.valid, 0);
    check_eq("t6_rst_data", out_if.data, 0);
    check_eq("t6_rst_parity_err", out_if.parity_err, 0);
    check_eq("t6_rst_frame_err", out_if.frame_err, 0);
    check_eq("t6_rst_overrun", out_if.overrun, 0);
    check_eq("t6_rst_busy", busy, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    d0 = delivered;
    push_exp(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    wait_drain("t6_drain");
    check_eq("t6_count", delivered, d0 + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
